// File: rtl/run_controller.sv
// Program sequencer: PC, IDLE/CLEAR/HOLD/RUN/DONE control, stall, halt, cycle count and watchdog; RUN_CTRL_SINGLE_STEP_EN adds step_i gating.
// Registered outputs update one cycle after the deciding edge; run_en_o is combinational; stall_i (and step_i) hold the PC in place.
module run_controller #(
    parameter int PC_W         = 32,
    parameter int PC_STEP      = 4,
    parameter int OFFSET_W     = 8,
    parameter int RESET_PC     = 0,
    parameter int CLEAR_CYCLES = 4,
    parameter int CNT_W        = 16,
    parameter int MAX_CYCLES   = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                halt_i,
    input  logic                branch_taken_i,
    input  logic [OFFSET_W-1:0] branch_offset_i,
    input  logic                stall_i,
`ifdef RUN_CTRL_SINGLE_STEP_EN
    input  logic                step_i,
`endif
    output logic [PC_W-1:0]     pc_o,
    output logic                run_en_o,
    output logic                clear_o,
    output logic                done_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    cycle_count_o
);

    localparam int               CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_INIT  = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]  PC_INC   = PC_W'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CLR_W-1:0] clr_cnt_q;
    logic             clear_q, done_q, timeout_q;
    logic             exec, count_en, halt_go, wd_go;
    logic [PC_W-1:0]  off_ext;

`ifdef RUN_CTRL_SINGLE_STEP_EN
    assign count_en = step_i;
    assign exec     = step_i & ~stall_i;
`else
    assign count_en = 1'b1;
    assign exec     = ~stall_i;
`endif

    assign run_en_o = (state_q == S_RUN) & exec;
    assign halt_go  = halt_i & exec;
    // Only counted cycles can trip the watchdog, so an idle step cycle never fires it early.
    assign wd_go    = (MAX_CYCLES != 0) && count_en && (cnt_q == WD_LAST);
    assign off_ext  = PC_W'($signed(branch_offset_i));

    always_comb begin
        pc_d = pc_q;
        if (exec) begin
            if (branch_taken_i) pc_d = pc_q + off_ext;
            else                pc_d = pc_q + PC_INC;
        end
        cnt_d = cnt_q;
        if (count_en && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_INIT;
            cnt_q     <= '0;
            clr_cnt_q <= '0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q   <= S_CLEAR;
                        pc_q      <= PC_INIT;
                        cnt_q     <= '0;
                        clr_cnt_q <= CLR_LAST;
                        clear_q   <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == '0) begin
                        state_q <= S_HOLD;
                        clear_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q - CLR_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!start_i) state_q <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    if (halt_go) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                        if (wd_go) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign clear_o       = clear_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = cnt_q;

endmodule
